// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

   localparam int DEPTH_DEFAULT = 4;
   localparam int WORD_BYTES    = 4;
   localparam int AW_DEFAULT    = 32;
   localparam int DW_DEFAULT    = 32;

   typedef enum logic {
      FETCH,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [DW_DEFAULT-1:0] instr;
      logic [AW_DEFAULT-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - PC, instruction-memory and decode signals of the fetch queue
interface fetch_queue_if import fetch_pkg::*; #(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
);

   logic [AW-1:0] pc;
   logic          pc_advance;
   logic          redirect;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          instr_valid;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;

   modport master (
      input  pc, redirect, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
      output pc_advance, imem_req, imem_addr, instr_valid, instr, instr_pc
   );

   modport slave (
      output pc, redirect, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
      input  pc_advance, imem_req, imem_addr, instr_valid, instr, instr_pc
   );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// rtl/fetch_queue_sync_fifo.sv - first-word fall-through FIFO with flush
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (do_pop)  rptr <= rptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

   // An empty FIFO presents zeros so downstream never sees stale words.
   assign pop_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction fetch with in-order response buffering and redirect flush
module fetch_queue import fetch_pkg::*; #(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = AW_DEFAULT,
   parameter int DW    = DW_DEFAULT
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int OFS = $clog2(WORD_BYTES);

   fetch_state_e  state;
   fetch_state_e  state_next;
   logic [CW-1:0] drop;
   logic [CW-1:0] drop_next;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] buffered;
   logic [CW-1:0] used;
   logic          grant;
   logic          pend_full;
   logic          pend_empty;
   logic [AW-1:0] pend_pc;
   logic          ibuf_push;
   logic          ibuf_pop;
   logic          ibuf_full;
   logic          ibuf_empty;
   fetch_entry_t  ibuf_in;
   fetch_entry_t  ibuf_head;

   assign used  = outstanding + buffered;
   assign grant = bus.imem_req && bus.imem_gnt;

   // Pending-PC count doubles as the outstanding-request counter, stale ones included.
   sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_pend (
      .clk(clk), .rst(rst), .flush(1'b0),
      .push(grant), .push_data(bus.pc), .pop(bus.imem_rvalid),
      .pop_data(pend_pc), .full(pend_full), .empty(pend_empty), .count(outstanding)
   );

   assign ibuf_push = bus.imem_rvalid && drop == '0 && !bus.redirect;
   assign ibuf_pop  = bus.instr_valid && bus.instr_ready;
   assign ibuf_in   = '{instr: bus.imem_rdata, pc: pend_pc};

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
      .clk(clk), .rst(rst), .flush(bus.redirect),
      .push(ibuf_push), .push_data(ibuf_in), .pop(ibuf_pop),
      .pop_data(ibuf_head), .full(ibuf_full), .empty(ibuf_empty), .count(buffered)
   );

   // On redirect every request still unanswered after this cycle becomes stale.
   always_comb begin
      drop_next = drop;
      if (bus.redirect)
         drop_next = bus.imem_rvalid ? outstanding - CW'(1) : outstanding;
      else if (bus.imem_rvalid && drop != '0)
         drop_next = drop - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop <= '0;
      else     drop <= drop_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH:   if (bus.redirect && drop_next != '0) state_next = DRAIN;
         DRAIN:   if (drop_next == '0) state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      bus.imem_req   = !rst && state == FETCH && used < CW'(DEPTH) && !bus.redirect;
      bus.pc_advance = bus.imem_req && bus.imem_gnt;
   end

   assign bus.imem_addr   = {bus.pc[AW-1:OFS], {OFS{1'b0}}};
   assign bus.instr_valid = !ibuf_empty;
   assign bus.instr       = ibuf_head.instr;
   assign bus.instr_pc    = ibuf_head.pc;

   rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
      !(bus.imem_rvalid && pend_empty));

   no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      !((grant && pend_full) || (ibuf_push && ibuf_full)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector bench for fetch_queue
module tb_fetch_queue;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fetch_queue_if bus ();

   fetch_queue dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        redirect;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        e_req;
      logic        e_adv;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
   } vec_t;

   vec_t vecs[$];
   int   applied     = 0;
   int   checks      = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [31:0] pc, input logic redir, input logic gnt,
                      input logic rv, input logic [31:0] rdata, input logic rdy,
                      input logic e_req, input logic e_adv, input logic [31:0] e_addr,
                      input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_ipc);
      vec_t v;
      v.rst = r;       v.pc = pc;         v.redirect = redir; v.gnt = gnt;
      v.rvalid = rv;   v.rdata = rdata;   v.ready = rdy;
      v.e_req = e_req; v.e_adv = e_adv;   v.e_addr = e_addr;
      v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
      vecs.push_back(v);
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic e_adv,
                             input logic [31:0] e_addr, input logic e_valid,
                             input logic [31:0] e_instr, input logic [31:0] e_ipc);
      chk({tag, " imem_req"},    32'(bus.imem_req),    32'(e_req));
      chk({tag, " pc_advance"},  32'(bus.pc_advance),  32'(e_adv));
      chk({tag, " imem_addr"},   bus.imem_addr,        e_addr);
      chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(e_valid));
      chk({tag, " instr"},       bus.instr,            e_instr);
      chk({tag, " instr_pc"},    bus.instr_pc,         e_ipc);
   endtask

   task automatic run_vecs(input string tag);
      foreach (vecs[i]) begin
         @(negedge clk);
         rst             = vecs[i].rst;
         bus.pc          = vecs[i].pc;
         bus.redirect    = vecs[i].redirect;
         bus.imem_gnt    = vecs[i].gnt;
         bus.imem_rvalid = vecs[i].rvalid;
         bus.imem_rdata  = vecs[i].rdata;
         bus.instr_ready = vecs[i].ready;
         #1;
         applied++;
         check_outs($sformatf("%s[%0d]", tag, i), vecs[i].e_req, vecs[i].e_adv,
                    vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_ipc);
      end
      vecs.delete();
   endtask

   initial begin
      rst             = 1'b1;
      bus.pc          = '0;
      bus.redirect    = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.instr_ready = 1'b0;

      // Streaming: grant every cycle, response one cycle later, decode always ready.
      //  rst pc           rd gn rv rdata         rdy req adv addr         vld instr         ipc
      add(1, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h0,        0, 1, 0, 32'h0,        1,  1,  1,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h4,        0, 1, 1, 32'h13,       1,  1,  1,  32'h4,       0,  32'h0,        32'h0);
      add(0, 32'h8,        0, 1, 1, 32'h13,       1,  1,  1,  32'h8,       1,  32'h13,       32'h0);
      add(0, 32'hC,        0, 1, 1, 32'h13,       1,  1,  1,  32'hC,       1,  32'h13,       32'h4);
      add(0, 32'h10,       0, 0, 1, 32'h13,       1,  1,  0,  32'h10,      1,  32'h13,       32'h8);
      add(0, 32'h10,       0, 0, 0, 32'h0,        1,  1,  0,  32'h10,      1,  32'h13,       32'hC);
      add(0, 32'h10,       0, 0, 0, 32'h0,        1,  1,  0,  32'h10,      0,  32'h0,        32'h0);
      run_vecs("stream");

      // Decode stalled: credit stops at four, then drains in order and fetch resumes at 0x10.
      add(1, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h0,        0, 1, 0, 32'h0,        0,  1,  1,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h4,        0, 1, 1, 32'hA0,       0,  1,  1,  32'h4,       0,  32'h0,        32'h0);
      add(0, 32'h8,        0, 1, 1, 32'hA1,       0,  1,  1,  32'h8,       1,  32'hA0,       32'h0);
      add(0, 32'hC,        0, 1, 1, 32'hA2,       0,  1,  1,  32'hC,       1,  32'hA0,       32'h0);
      add(0, 32'h10,       0, 1, 1, 32'hA3,       0,  0,  0,  32'h10,      1,  32'hA0,       32'h0);
      add(0, 32'h10,       0, 1, 0, 32'h0,        0,  0,  0,  32'h10,      1,  32'hA0,       32'h0);
      add(0, 32'h10,       0, 1, 0, 32'h0,        0,  0,  0,  32'h10,      1,  32'hA0,       32'h0);
      add(0, 32'h10,       0, 1, 0, 32'h0,        1,  0,  0,  32'h10,      1,  32'hA0,       32'h0);
      add(0, 32'h10,       0, 1, 0, 32'h0,        1,  1,  1,  32'h10,      1,  32'hA1,       32'h4);
      add(0, 32'h14,       0, 1, 1, 32'hA4,       1,  1,  1,  32'h14,      1,  32'hA2,       32'h8);
      add(0, 32'h18,       0, 0, 1, 32'hA5,       1,  1,  0,  32'h18,      1,  32'hA3,       32'hC);
      add(0, 32'h18,       0, 0, 0, 32'h0,        1,  1,  0,  32'h18,      1,  32'hA4,       32'h10);
      add(0, 32'h18,       0, 0, 0, 32'h0,        1,  1,  0,  32'h18,      1,  32'hA5,       32'h14);
      add(0, 32'h18,       0, 0, 0, 32'h0,        1,  1,  0,  32'h18,      0,  32'h0,        32'h0);
      run_vecs("stall");

      // Redirect with three outstanding: all three responses dropped, then fetch at 0x100.
      add(1, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h20,       0, 1, 0, 32'h0,        1,  1,  1,  32'h20,      0,  32'h0,        32'h0);
      add(0, 32'h24,       0, 1, 0, 32'h0,        1,  1,  1,  32'h24,      0,  32'h0,        32'h0);
      add(0, 32'h28,       0, 1, 0, 32'h0,        1,  1,  1,  32'h28,      0,  32'h0,        32'h0);
      add(0, 32'h2C,       0, 0, 0, 32'h0,        1,  1,  0,  32'h2C,      0,  32'h0,        32'h0);
      add(0, 32'h100,      1, 0, 0, 32'h0,        1,  0,  0,  32'h100,     0,  32'h0,        32'h0);
      add(0, 32'h100,      0, 1, 0, 32'h0,        1,  0,  0,  32'h100,     0,  32'h0,        32'h0);
      add(0, 32'h100,      0, 1, 1, 32'hDEAD0020, 1,  0,  0,  32'h100,     0,  32'h0,        32'h0);
      add(0, 32'h100,      0, 1, 1, 32'hDEAD0024, 1,  0,  0,  32'h100,     0,  32'h0,        32'h0);
      add(0, 32'h100,      0, 1, 1, 32'hDEAD0028, 1,  0,  0,  32'h100,     0,  32'h0,        32'h0);
      add(0, 32'h100,      0, 1, 0, 32'h0,        1,  1,  1,  32'h100,     0,  32'h0,        32'h0);
      add(0, 32'h104,      0, 0, 1, 32'hC100,     1,  1,  0,  32'h104,     0,  32'h0,        32'h0);
      add(0, 32'h104,      0, 0, 0, 32'h0,        1,  1,  0,  32'h104,     1,  32'hC100,     32'h100);
      add(0, 32'h104,      0, 0, 0, 32'h0,        1,  1,  0,  32'h104,     0,  32'h0,        32'h0);
      run_vecs("drain3");

      // Redirect coinciding with the response for 0x40 while 0x44 is still outstanding.
      add(1, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h40,       0, 1, 0, 32'h0,        1,  1,  1,  32'h40,      0,  32'h0,        32'h0);
      add(0, 32'h44,       0, 1, 0, 32'h0,        1,  1,  1,  32'h44,      0,  32'h0,        32'h0);
      add(0, 32'h48,       0, 0, 0, 32'h0,        1,  1,  0,  32'h48,      0,  32'h0,        32'h0);
      add(0, 32'h200,      1, 0, 1, 32'hBAD40,    1,  0,  0,  32'h200,     0,  32'h0,        32'h0);
      add(0, 32'h200,      0, 1, 1, 32'hBAD44,    1,  0,  0,  32'h200,     0,  32'h0,        32'h0);
      add(0, 32'h200,      0, 1, 0, 32'h0,        1,  1,  1,  32'h200,     0,  32'h0,        32'h0);
      add(0, 32'h204,      0, 0, 1, 32'hD200,     1,  1,  0,  32'h204,     0,  32'h0,        32'h0);
      add(0, 32'h204,      0, 0, 0, 32'h0,        1,  1,  0,  32'h204,     1,  32'hD200,     32'h200);
      run_vecs("redir_rv");

      // Redirect with nothing outstanding flushes the buffer and fetch resumes next cycle.
      add(1, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h50,       0, 1, 0, 32'h0,        0,  1,  1,  32'h50,      0,  32'h0,        32'h0);
      add(0, 32'h54,       0, 0, 1, 32'hE50,      0,  1,  0,  32'h54,      0,  32'h0,        32'h0);
      add(0, 32'h54,       0, 0, 0, 32'h0,        0,  1,  0,  32'h54,      1,  32'hE50,      32'h50);
      add(0, 32'h300,      1, 1, 0, 32'h0,        0,  0,  0,  32'h300,     1,  32'hE50,      32'h50);
      add(0, 32'h300,      0, 1, 0, 32'h0,        0,  1,  1,  32'h300,     0,  32'h0,        32'h0);
      add(0, 32'h304,      0, 0, 1, 32'hE300,     1,  1,  0,  32'h304,     0,  32'h0,        32'h0);
      add(0, 32'h304,      0, 0, 0, 32'h0,        1,  1,  0,  32'h304,     1,  32'hE300,     32'h300);
      run_vecs("redir_idle");

      // Misaligned PC: aligned address out, unmodified PC delivered.
      add(1, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h102,      0, 1, 0, 32'h0,        1,  1,  1,  32'h100,     0,  32'h0,        32'h0);
      add(0, 32'h106,      0, 0, 1, 32'hF0,       1,  1,  0,  32'h104,     0,  32'h0,        32'h0);
      add(0, 32'h106,      0, 0, 0, 32'h0,        1,  1,  0,  32'h104,     1,  32'hF0,       32'h102);
      run_vecs("misalign");

      // Build two outstanding plus two buffered, then hit reset mid-cycle.
      add(1, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h0,        0, 1, 0, 32'h0,        0,  1,  1,  32'h0,       0,  32'h0,        32'h0);
      add(0, 32'h4,        0, 1, 1, 32'h11,       0,  1,  1,  32'h4,       0,  32'h0,        32'h0);
      add(0, 32'h8,        0, 1, 1, 32'h22,       0,  1,  1,  32'h8,       1,  32'h11,       32'h0);
      add(0, 32'hC,        0, 1, 0, 32'h0,        0,  1,  1,  32'hC,       1,  32'h11,       32'h0);
      add(0, 32'h10,       0, 1, 0, 32'h0,        0,  0,  0,  32'h10,      1,  32'h11,       32'h0);
      run_vecs("rst_build");

      #2;
      rst = 1'b1;
      #1;
      applied++;
      check_outs("rst_async", 1'b0, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0);

      add(0, 32'h60,       0, 1, 0, 32'h0,        1,  1,  1,  32'h60,      0,  32'h0,        32'h0);
      add(0, 32'h64,       0, 0, 1, 32'h66,       1,  1,  0,  32'h64,      0,  32'h0,        32'h0);
      add(0, 32'h64,       0, 0, 0, 32'h0,        1,  1,  0,  32'h64,      1,  32'h66,       32'h60);
      add(0, 32'h64,       0, 0, 0, 32'h0,        1,  1,  0,  32'h64,      0,  32'h0,        32'h0);
      run_vecs("rst_after");

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer end of the program counter.
- Takes the current PC, issues word-aligned requests to instruction memory over a req/gnt + rvalid interface, and buffers returned instructions with their PCs.
- Presents instructions to decode over a valid/ready handshake, and throttles the PC via `pc_advance`.
- On a taken branch (`redirect`), flushes queued instructions and discards responses still in flight.

Parameters:
- DEPTH, 4, maximum in-flight requests plus buffered instructions; power of two, ≥2.
- AW, 32, address / PC width.
- DW, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- pc  in  AW  current PC from the PC register.
- pc_advance  out  1  PC may step this cycle; high exactly when a request is granted.
- redirect  in  1  branch taken; flush everything older than the next PC.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  AW  request address, {pc[AW-1:2], 2'b00}.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  DW  response instruction.
- instr_valid  out  1  instruction available to decode.
- instr  out  DW  instruction word.
- instr_pc  out  AW  PC of that instruction.
- instr_ready  in  1  decode accepts this cycle.

Behaviour:
- Reset, asynchronous and active-high: all counters and FIFOs cleared, state = FETCH.
  - Outputs during/after reset: imem_req=0, pc_advance=0, instr_valid=0, instr=0, instr_pc=0.
- Credit:
  - `outstanding` = granted requests not yet responded to, including stale ones.
  - `used` = outstanding + buffered entries.
  - imem_req = (state==FETCH) && used<DEPTH && !redirect. This is combinational; imem_addr follows pc combinationally.
- Grant:
  - When imem_req && imem_gnt: pc_advance=1 and the address is pushed into the pending-PC FIFO.
  - Responses return strictly in order, ≥1 cycle after grant. An rvalid with outstanding==0 is illegal and asserted in simulation.
- Response:
  - On imem_rvalid, pop the pending PC.
  - If the drop counter is >0, decrement it and discard the data.
  - Otherwise push {imem_rdata, pc} into the instruction buffer.
- Decode handshake:
  - instr_valid = buffer non-empty.
  - instr/instr_pc come from the buffer head, with no bubble (first-word fall-through).
  - A pop occurs on instr_valid && instr_ready.
- States:
  - FETCH: normal operation.
  - DRAIN: entered on redirect when any request is outstanding.
    - Requests are blocked until drop==0, then return to FETCH.
    - Redirect with outstanding==0 stays in FETCH; requests resume the next cycle with the new pc.
- Redirect, in the same cycle:
  - Instruction buffer cleared.
  - drop := outstanding, plus 1 if the pending grant is counted (imem_gnt cannot occur since imem_req=0), minus 1 if a non-dropped rvalid arrives the same cycle (that data is discarded).
  - instr_valid goes 0 next cycle.
  - A decode pop in the redirect cycle is still a legal handshake.
- Redirect during DRAIN: buffer already empty, drop recomputed as outstanding (monotone, no overflow).
- Full: used==DEPTH → imem_req=0, pc_advance=0. The buffer can never overflow because credit covers in-flight responses.
- Simultaneous: grant + rvalid + pop in one cycle update all counters consistently; net occupancy changes by +1 −1.
- Counter widths: $clog2(DEPTH)+1 bits; no wrap allowed.
- Misaligned pc (pc[1:0]≠0): address forced aligned; instr_pc carries the unmodified pc.

Decomposition:
- Shared package `fetch_pkg`:
  - fetch_entry_t struct {instr, pc}.
  - Parameter constants DEPTH_DEFAULT and WORD_BYTES=4.
  - State enum fetch_state_e {FETCH, DRAIN}.
- One sub-module `sync_fifo` (parameterised width/depth, push/pop/flush, full/empty, first-word fall-through).
  - Instantiated twice: pending-PC FIFO (AW wide) and instruction buffer (fetch_entry_t wide).

Test Plan:
- Reset release, pc=0x0, gnt always 1, rvalid 1 cycle after grant, instr_ready=1:
  - pc_advance high every cycle.
  - Decode sees 0x0, 0x4, 0x8 with rdata=0x00000013 each, one per cycle after 2-cycle startup.
- instr_ready=0 for 10 cycles, otherwise as above:
  - Exactly 4 grants, then imem_req=0.
  - Buffer holds PCs 0x0–0xC.
  - Release ready → drained in order, fetch resumes at 0x10.
- 3 outstanding (gnt at PCs 0x20/0x24/0x28, rvalid delayed 5 cycles), redirect with pc=0x100:
  - Enters DRAIN, 3 responses discarded, no instr_valid.
  - Next request addr=0x100; first delivered instr_pc=0x100.
- Redirect in the same cycle as an rvalid for pc 0x40 while 0x44 is outstanding:
  - 0x40 data discarded, drop=1, 0x44 discarded; instr_valid stays 0 until 0x200 is returned.
- Assert rst mid-stream with 2 outstanding and 2 buffered:
  - Outputs 0 immediately (asynchronous).
  - After release, no stale data appears and the first request is addr=pc.
- pc=0x102, gnt=1:
  - imem_addr=0x100; delivered instr_pc=0x102.
